// File: rtl/rggen_backdoor_arbiter_pkg.sv
// rggen_backdoor_arbiter_pkg: state encoding and width helper shared by the backdoor arbiter files.
package rggen_backdoor_arbiter_pkg;
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACCESS  = 2'd1;
   localparam logic [1:0] ST_PENDING = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      ACCESS  = ST_ACCESS,
      PENDING = ST_PENDING
   } state_t;

   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/rggen_backdoor_rr_arbiter.sv
// rggen_backdoor_rr_arbiter: combinational round-robin pick, searching upward from pointer with wrap.
module rggen_backdoor_rr_arbiter
   import rggen_backdoor_arbiter_pkg::*;
#(
   parameter int CHANNELS = 2,
   localparam int IW = clog2_min1(CHANNELS)
) (
   input  logic [CHANNELS-1:0] request,
   input  logic [IW-1:0]       pointer,
   output logic [CHANNELS-1:0] grant,
   output logic [IW-1:0]       index
);
   logic [IW-1:0] c;
   logic          hit;

   always_comb begin
      grant = '0;
      index = '0;
      hit   = 1'b0;
      c     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         c = IW'((int'(pointer) + i) % CHANNELS);
         if (!hit && request[c]) begin
            hit      = 1'b1;
            grant[c] = 1'b1;
            index    = c;
         end
      end
   end
endmodule

// File: rtl/rggen_backdoor_arbiter.sv
// rggen_backdoor_arbiter: round-robin multi-channel backdoor access with frontdoor-collision retry.
// Define RGGEN_BACKDOOR_PENDING_TIMEOUT_EN to abort accesses stuck in PENDING for TIMEOUT_CYCLES.
module rggen_backdoor_arbiter
   import rggen_backdoor_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int CHANNELS       = 2,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_frontdoor_valid,
   input  logic                           i_frontdoor_ready,
   input  logic [CHANNELS-1:0]            i_bd_valid,
   output logic [CHANNELS-1:0]            o_bd_ready,
   output logic                           o_bd_error,
   input  logic [CHANNELS*DATA_WIDTH-1:0] i_bd_read_mask,
   input  logic [CHANNELS*DATA_WIDTH-1:0] i_bd_write_mask,
   input  logic [CHANNELS*DATA_WIDTH-1:0] i_bd_write_data,
   output logic [DATA_WIDTH-1:0]          o_bd_read_data,
   output logic [DATA_WIDTH-1:0]          o_bd_value,
   output logic                           o_backdoor_valid,
   output logic                           o_pending_valid,
   output logic [DATA_WIDTH-1:0]          o_read_mask,
   output logic [DATA_WIDTH-1:0]          o_write_mask,
   output logic [DATA_WIDTH-1:0]          o_write_data,
   input  logic [DATA_WIDTH-1:0]          i_read_data,
   input  logic [DATA_WIDTH-1:0]          i_value
);
   localparam int IW = clog2_min1(CHANNELS);

   if (CHANNELS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("rggen_backdoor_arbiter: CHANNELS and TIMEOUT_CYCLES must be >= 1");
   end

   state_t              state;
   logic [IW-1:0]       pointer;
   logic [IW-1:0]       index;
   logic [IW-1:0]       pick;
   logic [CHANNELS-1:0] grant;
   logic                done;
   logic                abort;

   rggen_backdoor_rr_arbiter #(.CHANNELS(CHANNELS)) u_rr (
      .request (i_bd_valid),
      .pointer (pointer),
      .grant   (grant),
      .index   (pick)
   );

`ifdef RGGEN_BACKDOOR_PENDING_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] count;

   always_ff @(posedge i_clk)
      if (i_rst || state != PENDING) count <= '0;
      else count <= count + 1'b1;

   // a frontdoor completion in the same cycle wins and leads to a normal retry
   assign abort = state == PENDING && !i_frontdoor_ready && count == TW'(TIMEOUT_CYCLES);
`else
   assign abort = 1'b0;
`endif

   assign done             = state == ACCESS && !i_frontdoor_valid;
   assign o_backdoor_valid = state != IDLE;
   assign o_pending_valid  = state == PENDING;
   assign o_bd_ready       = (done || abort) ? CHANNELS'(1) << index : '0;
   assign o_bd_error       = abort;
   assign o_bd_read_data   = done ? i_read_data : '0;
   assign o_bd_value       = i_value;

   always_ff @(posedge i_clk)
      if (i_rst) begin
         state        <= IDLE;
         pointer      <= '0;
         index        <= '0;
         o_read_mask  <= '0;
         o_write_mask <= '0;
         o_write_data <= '0;
      end else begin
         case (state)
            IDLE:
               if (|grant) begin
                  state        <= ACCESS;
                  index        <= pick;
                  pointer      <= (pick == IW'(CHANNELS - 1)) ? '0 : pick + 1'b1;
                  o_read_mask  <= i_bd_read_mask[pick*DATA_WIDTH +: DATA_WIDTH];
                  o_write_mask <= i_bd_write_mask[pick*DATA_WIDTH +: DATA_WIDTH];
                  o_write_data <= i_bd_write_data[pick*DATA_WIDTH +: DATA_WIDTH];
               end
            ACCESS:
               if (!i_frontdoor_valid) state <= IDLE;
               else if (!i_frontdoor_ready) state <= PENDING;
            PENDING:
               if (i_frontdoor_ready) state <= ACCESS;
               else if (abort) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_rggen_backdoor_arbiter.sv
// tb_rggen_backdoor_arbiter: directed checks of grant order, collision retry, reset and timeout.
module tb_rggen_backdoor_arbiter;
   localparam int DW = 32;
   localparam int CH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             fv, fr;
   logic [CH-1:0]    valid, ready;
   logic             err;
   logic [CH*DW-1:0] rmask, wmask, wdata;
   logic [DW-1:0]    rd_out, value_out, rm, wm, wd, rdata, value;
   logic             bd_valid, pend;
   int               tests = 0;
   int               fails = 0;
   logic             found;
   int               n;
   logic [CH-1:0]    got_ready;
   logic             got_err, got_pend;
   logic [DW-1:0]    got_rd;
   logic [CH-1:0]    held = '0;

   always #5 clk = ~clk;

   rggen_backdoor_arbiter #(.DATA_WIDTH(DW), .CHANNELS(CH), .TIMEOUT_CYCLES(8)) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_frontdoor_valid (fv),
      .i_frontdoor_ready (fr),
      .i_bd_valid        (valid),
      .o_bd_ready        (ready),
      .o_bd_error        (err),
      .i_bd_read_mask    (rmask),
      .i_bd_write_mask   (wmask),
      .i_bd_write_data   (wdata),
      .o_bd_read_data    (rd_out),
      .o_bd_value        (value_out),
      .o_backdoor_valid  (bd_valid),
      .o_pending_valid   (pend),
      .o_read_mask       (rm),
      .o_write_mask      (wm),
      .o_write_data      (wd),
      .i_read_data       (rdata),
      .i_value           (value)
   );

   // requesters must hold valid until their ready
   always @(posedge clk) begin
      for (int c = 0; c < CH; c++)
         if (held[c] && !valid[c]) $error("channel %0d dropped valid before ready", c);
      held <= rst ? '0 : valid & ~ready;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; valid = '0; fv = 1'b0; fr = 1'b0;
      rmask = '0; wmask = '0; wdata = '0; rdata = '0; value = 32'h1234_5678;
      repeat (2) @(negedge clk);
      #1;
      check("rst_bdv", bd_valid, 0);
      check("rst_pend", pend, 0);
      check("rst_ready", ready, 0);
      check("rst_rmask", rm, 0);
      check("value", value_out, 32'h1234_5678);

      @(negedge clk); rst = 1'b0; valid = 4'b0001; rmask[31:0] = 32'hFFFF_FFFF; rdata = 32'hA5A5_A5A5; #1;
      check("single_idle_ready", ready, 0);
      check("single_idle_bdv", bd_valid, 0);
      @(negedge clk); #1;
      check("single_bdv", bd_valid, 1);
      check("single_ready", ready, 4'b0001);
      check("single_rdata", rd_out, 32'hA5A5_A5A5);
      check("single_rmask", rm, 32'hFFFF_FFFF);
      check("single_err", err, 0);
      @(negedge clk); valid = '0; #1;
      check("single_after_bdv", bd_valid, 0);
      check("single_after_ready", ready, 0);
      check("single_rmask_hold", rm, 32'hFFFF_FFFF);

      @(negedge clk); valid = 4'b0010; fv = 1'b1; fr = 1'b0; #1;
      check("coll_idle_pend", pend, 0);
      @(negedge clk); #1;
      check("coll_acc_bdv", bd_valid, 1);
      check("coll_acc_ready", ready, 0);
      check("coll_acc_pend", pend, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); if (i == 2) fr = 1'b1; #1;
         check($sformatf("coll_pend%0d", i), pend, 1);
         check($sformatf("coll_pend_ready%0d", i), ready, 0);
      end
      @(negedge clk); fv = 1'b0; fr = 1'b0; #1;
      check("coll_retry_pend", pend, 0);
      check("coll_retry_ready", ready, 4'b0010);
      @(negedge clk); valid = '0;

      @(negedge clk); valid = 4'b1000; fv = 1'b1; fr = 1'b1; #1;
      @(negedge clk); #1;
      check("sim_pend", pend, 0);
      check("sim_ready", ready, 0);
      check("sim_bdv", bd_valid, 1);
      @(negedge clk); fv = 1'b0; fr = 1'b0; #1;
      check("sim_pend2", pend, 0);
      check("sim_ready2", ready, 4'b1000);

      @(negedge clk);
      for (int c = 0; c < CH; c++) wdata[c*DW +: DW] = 32'h1111_1111 * (c + 1);
      valid = 4'b1111; #1;
      check("rr_idle_ready", ready, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         check($sformatf("rr_grant%0d", i), ready, 4'b0001 << (i % 4));
         check($sformatf("rr_wdata%0d", i), wd, 32'h1111_1111 * ((i % 4) + 1));
         @(negedge clk); if (i >= 4) valid[i % 4] = 1'b0; #1;
         check($sformatf("rr_gap%0d", i), ready, 0);
      end

      @(negedge clk); valid = 4'b0100; fv = 1'b1; fr = 1'b0; #1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      check("rstp_pend", pend, 1);
      @(negedge clk); rst = 1'b1; #1;
      check("rstp_in_rst_ready", ready, 0);
      @(negedge clk); rst = 1'b0; fv = 1'b0; valid = 4'b1100; #1;
      check("rstp_bdv", bd_valid, 0);
      check("rstp_pend2", pend, 0);
      check("rstp_ready", ready, 0);
      @(negedge clk); #1;
      check("rstp_regrant", ready, 4'b0100);
      @(negedge clk); valid = 4'b1000; #1;
      check("rstp_idle", ready, 0);
      @(negedge clk); #1;
      check("rstp_next", ready, 4'b1000);
      @(negedge clk); valid = '0;

      @(negedge clk); valid = 4'b0010; fv = 1'b1; fr = 1'b0; rdata = 32'hDEAD_BEEF; #1;
      @(negedge clk); #1;
      check("tmo_acc_ready", ready, 0);
      found = 1'b0; n = 0; got_ready = '0; got_err = 1'b0; got_rd = '0; got_pend = 1'b0;
      for (int i = 1; i <= 100 && !found; i++) begin
         @(negedge clk); #1;
         if (ready != 0) begin
            found = 1'b1; n = i; got_ready = ready; got_err = err; got_rd = rd_out; got_pend = pend;
         end
      end
`ifdef RGGEN_BACKDOOR_PENDING_TIMEOUT_EN
      check("tmo_found", found, 1);
      check("tmo_cycle", n, 9);
      check("tmo_ready", got_ready, 4'b0010);
      check("tmo_err", got_err, 1);
      check("tmo_rdata", got_rd, 0);
      check("tmo_pend", got_pend, 1);
      @(negedge clk); valid = '0; #1;
      check("tmo_after_pend", pend, 0);
      check("tmo_after_bdv", bd_valid, 0);
`else
      check("no_tmo", found, 0);
      check("no_tmo_pend", pend, 1);
      @(negedge clk); fr = 1'b1; #1;
      check("drain_hold_ready", ready, 0);
      @(negedge clk); fv = 1'b0; fr = 1'b0; #1;
      check("drain_ready", ready, 4'b0010);
      check("drain_err", err, 0);
      check("drain_rdata", rd_out, 32'hDEAD_BEEF);
      @(negedge clk); valid = '0;
`endif
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
